pc_fetch_ctrl: RTL and testbench

Sequences the program counter and instruction fetch for the core front end.
- Owns the PC register and computes the next PC: sequential pc+4, or a redirect from the execute stage.
- Issues one outstanding request at a time to instruction memory over a req/gnt/rvalid handshake.
- Delivers {pc, inst} to decode through a registered valid/stall interface.
- Flushes in-flight or buffered fetches when a redirect arrives.

---
 rtl/pc_fetch_ctrl_if.sv | 26 ++
 rtl/pc_fetch_ctrl.sv | 168 ++++++++++++++++
 tb/tb_pc_fetch_ctrl.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/pc_fetch_ctrl_if.sv
// Front-end fetch bus: execute redirect, instruction-memory handshake and decode delivery.
// master = pc_fetch_ctrl, slave = the memory/decode side.
interface pc_fetch_ctrl_if;
  logic        branch_valid;
  logic [31:0] branch_pc;
  logic        stall;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_gnt;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        if_valid;
  logic [31:0] if_pc;
  logic [31:0] if_inst;
  logic        misalign;

  modport master (
    input  branch_valid, branch_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    output imem_req, imem_addr, if_valid, if_pc, if_inst, misalign
  );

  modport slave (
    output branch_valid, branch_pc, stall, imem_gnt, imem_rvalid, imem_rdata,
    input  imem_req, imem_addr, if_valid, if_pc, if_inst, misalign
  );
endinterface

// File: rtl/pc_fetch_ctrl.sv
// PC sequencing and single-outstanding instruction fetch with redirect flush.
// Optional misaligned-redirect trap enabled by defining PC_ALIGN_CHK_EN.
//
// state | meaning
// BOOT  | first cycle after reset release; any stray response is ignored
// REQ   | request pc (req held low while decode slot is full and stalled)
// WAIT  | one request outstanding; kill drops its response
// HOLD  | response parked in buffer until decode releases stall
module pc_fetch_ctrl #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] TRAP_PC  = 32'h0000_0100
) (
  input  logic clk,
  input  logic rst_n,
  pc_fetch_ctrl_if.master bus
);

  typedef enum logic [1:0] {BOOT, REQ, WAIT, HOLD} state_t;

  localparam logic [31:0] NOP = 32'h0000_0013;

  state_t      state, state_d;
  logic [31:0] pc, pc_d;
  logic [31:0] fetch_pc, fetch_pc_d;
  logic        kill, kill_d;
  logic        out_valid, out_valid_d;
  logic [31:0] out_pc, out_pc_d;
  logic [31:0] out_inst, out_inst_d;
  logic [31:0] buf_pc, buf_pc_d;
  logic [31:0] buf_inst, buf_inst_d;

  logic        slot_busy;
  logic        req;
  logic        granted;
  logic        misaligned;
  logic [31:0] redirect_pc;

`ifdef PC_ALIGN_CHK_EN
  logic misalign_q;

  assign misaligned = |bus.branch_pc[1:0];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) misalign_q <= 1'b0;
    else        misalign_q <= bus.branch_valid & misaligned;
  end

  assign bus.misalign = misalign_q;
`else
  assign misaligned   = 1'b0;
  assign bus.misalign = 1'b0;
`endif

  assign redirect_pc = misaligned ? {TRAP_PC[31:2], 2'b00}
                                  : {bus.branch_pc[31:2], 2'b00};

  assign slot_busy = out_valid & bus.stall;
  assign req       = (state == REQ) & ~slot_busy;
  assign granted   = req & bus.imem_gnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= BOOT;
      pc        <= {RESET_PC[31:2], 2'b00};
      fetch_pc  <= {RESET_PC[31:2], 2'b00};
      kill      <= 1'b0;
      out_valid <= 1'b0;
      out_pc    <= 32'h0;
      out_inst  <= NOP;
      buf_pc    <= 32'h0;
      buf_inst  <= NOP;
    end else begin
      state     <= state_d;
      pc        <= pc_d;
      fetch_pc  <= fetch_pc_d;
      kill      <= kill_d;
      out_valid <= out_valid_d;
      out_pc    <= out_pc_d;
      out_inst  <= out_inst_d;
      buf_pc    <= buf_pc_d;
      buf_inst  <= buf_inst_d;
    end
  end

  always_comb begin
    state_d     = state;
    pc_d        = pc;
    fetch_pc_d  = fetch_pc;
    kill_d      = kill;
    out_valid_d = out_valid;
    out_pc_d    = out_pc;
    out_inst_d  = out_inst;
    buf_pc_d    = buf_pc;
    buf_inst_d  = buf_inst;

    if (out_valid && !bus.stall) out_valid_d = 1'b0;

    case (state)
      BOOT: state_d = REQ;
      REQ: begin
        if (granted) begin
          fetch_pc_d = pc;
          pc_d       = pc + 32'd4;
          state_d    = WAIT;
        end
      end
      WAIT: begin
        if (bus.imem_rvalid) begin
          if (kill) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else if (!slot_busy) begin
            out_valid_d = 1'b1;
            out_pc_d    = fetch_pc;
            out_inst_d  = bus.imem_rdata;
            state_d     = REQ;
          end else begin
            buf_pc_d   = fetch_pc;
            buf_inst_d = bus.imem_rdata;
            state_d    = HOLD;
          end
        end
      end
      HOLD: begin
        if (!bus.stall) begin
          out_valid_d = 1'b1;
          out_pc_d    = buf_pc;
          out_inst_d  = buf_inst;
          state_d     = REQ;
        end
      end
      default: state_d = BOOT;
    endcase

    // Redirect overrides everything above; leaving HOLD discards the buffer.
    if (bus.branch_valid) begin
      out_valid_d = 1'b0;
      pc_d        = redirect_pc;
      case (state)
        REQ: begin
          if (granted) begin
            kill_d  = 1'b1;
            state_d = WAIT;
          end else begin
            state_d = REQ;
          end
        end
        WAIT: begin
          if (bus.imem_rvalid) begin
            kill_d  = 1'b0;
            state_d = REQ;
          end else begin
            kill_d  = 1'b1;
          end
        end
        HOLD:    state_d = REQ;
        default: state_d = REQ;
      endcase
    end
  end

  assign bus.imem_req  = req;
  assign bus.imem_addr = pc;
  assign bus.if_valid  = out_valid;
  assign bus.if_pc     = out_pc;
  assign bus.if_inst   = out_inst;

endmodule

// File: tb/tb_pc_fetch_ctrl.sv
// Directed bench for pc_fetch_ctrl: memory model grants on the second request cycle
// and answers after a programmable latency.
module tb_pc_fetch_ctrl;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pc_fetch_ctrl_if ifc ();
  pc_fetch_ctrl dut (.clk(clk), .rst_n(rst_n), .bus(ifc));

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int lat = 0;

  logic [31:0] q_pc[$];
  logic [31:0] q_inst[$];
  int          q_cyc[$];

  logic        gq;
  logic        pend;
  int          cnt;
  logic [31:0] paddr;

  function automatic logic [31:0] memf(input logic [31:0] a);
    case (a)
      32'h0:   return 32'h11;
      32'h4:   return 32'h22;
      32'h8:   return 32'h33;
      default: return a ^ 32'h1357_0000;
    endcase
  endfunction

  assign ifc.imem_gnt    = gq & ifc.imem_req;
  assign ifc.imem_rvalid = pend && (cnt == 0);
  assign ifc.imem_rdata  = memf(paddr);

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gq <= 1'b0; pend <= 1'b0; cnt <= 0; paddr <= 32'h0;
    end else begin
      gq <= ifc.imem_req & ~ifc.imem_gnt;
      if (pend) begin
        if (cnt == 0) pend <= 1'b0;
        else          cnt  <= cnt - 1;
      end
      if (ifc.imem_gnt) begin
        pend <= 1'b1; cnt <= lat; paddr <= ifc.imem_addr;
      end
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (ifc.imem_req === 1'b1) begin
      checks++;
      assert (ifc.imem_addr[1:0] === 2'b00) else begin
        errors++;
        $error("FAIL addr_align observed=%h expected low bits 00", ifc.imem_addr);
      end
    end
    if (rst_n && ifc.if_valid === 1'b1 && ifc.stall === 1'b0) begin
      q_pc.push_back(ifc.if_pc);
      q_inst.push_back(ifc.if_inst);
      q_cyc.push_back(cyc);
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic pop_chk(input string tag, input logic [31:0] epc, output int stamp);
    int n = 0;
    stamp = 0;
    while (q_pc.size() == 0 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (q_pc.size() == 0) begin
      checks++;
      errors++;
      $error("FAIL %s observed=timeout expected=pc %h", tag, epc);
    end else begin
      chk({tag, "_pc"}, q_pc.pop_front(), epc);
      chk({tag, "_inst"}, q_inst.pop_front(), memf(epc));
      stamp = q_cyc.pop_front();
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Land #1 into the first WAIT cycle of a fresh grant, with the delivery queue emptied.
  task automatic at_wait(input string tag);
    int n = 0;
    @(negedge clk);
    while (ifc.imem_gnt !== 1'b1 && n < 80) begin
      @(negedge clk);
      n++;
    end
    if (ifc.imem_gnt !== 1'b1) begin
      checks++;
      errors++;
      $error("FAIL %s observed=no grant expected=grant", tag);
    end
    step(1);
    q_pc.delete(); q_inst.delete(); q_cyc.delete();
  endtask

  task automatic redirect(input logic [31:0] target);
    ifc.branch_valid = 1'b1;
    ifc.branch_pc    = target;
    step(1);
    ifc.branch_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int s0, s1, s2, n;
    ifc.stall = 1'b0;
    ifc.branch_valid = 1'b0;
    ifc.branch_pc = 32'h0;

    // Reset state
    @(negedge clk);
    chk("rst_req", {31'h0, ifc.imem_req}, 32'h0);
    chk("rst_addr", ifc.imem_addr, 32'h0);
    chk("rst_valid", {31'h0, ifc.if_valid}, 32'h0);
    chk("rst_pc", ifc.if_pc, 32'h0);
    chk("rst_inst", ifc.if_inst, 32'h13);
    chk("rst_misalign", {31'h0, ifc.misalign}, 32'h0);
    step(1);
    rst_n = 1'b1;

    // Sequential stream, one delivery every 3 cycles
    pop_chk("seq0", 32'h0, s0);
    pop_chk("seq1", 32'h4, s1);
    pop_chk("seq2", 32'h8, s2);
    chk("rate01", s1 - s0, 32'd3);
    chk("rate12", s2 - s1, 32'd3);

    // Reset mid-operation, then stall on the second delivery
    rst_n = 1'b0;
    @(negedge clk);
    chk("rst2_valid", {31'h0, ifc.if_valid}, 32'h0);
    chk("rst2_inst", ifc.if_inst, 32'h13);
    chk("rst2_addr", ifc.imem_addr, 32'h0);
    q_pc.delete(); q_inst.delete(); q_cyc.delete();
    step(1);
    rst_n = 1'b1;
    n = 0;
    while (ifc.if_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("first_valid", {31'h0, ifc.if_valid}, 32'h1);
    step(3);
    ifc.stall = 1'b1;
    repeat (5) begin
      @(negedge clk);
      chk("stall_valid", {31'h0, ifc.if_valid}, 32'h1);
      chk("stall_pc", ifc.if_pc, 32'h4);
      chk("stall_req", {31'h0, ifc.imem_req}, 32'h0);
    end
    step(1);
    ifc.stall = 1'b0;
    pop_chk("st0", 32'h0, s0);
    pop_chk("st1", 32'h4, s1);
    pop_chk("st2", 32'h8, s2);

    // Redirect while waiting on a slow response
    lat = 3;
    at_wait("w200");
    redirect(32'h200);
    pop_chk("br200", 32'h200, s0);
    pop_chk("br204", 32'h204, s1);

    // Back-to-back redirects: latest wins
    at_wait("w300");
    redirect(32'h300);
    redirect(32'h400);
    pop_chk("br400", 32'h400, s0);
    pop_chk("br404", 32'h404, s1);

    // Redirect coincident with rvalid: response dropped
    at_wait("w500");
    step(3);
    redirect(32'h500);
    pop_chk("br500", 32'h500, s0);

    // PC wrap
    lat = 0;
    at_wait("wwrap");
    redirect(32'hFFFF_FFFC);
    pop_chk("wrap_top", 32'hFFFF_FFFC, s0);
    pop_chk("wrap_zero", 32'h0, s1);

    // Misaligned redirect
    at_wait("wmis");
    ifc.branch_valid = 1'b1;
    ifc.branch_pc    = 32'h202;
    @(negedge clk);
    chk("mis_same", {31'h0, ifc.misalign}, 32'h0);
    step(1);
    ifc.branch_valid = 1'b0;
    @(negedge clk);
`ifdef PC_ALIGN_CHK_EN
    chk("mis_pulse", {31'h0, ifc.misalign}, 32'h1);
    @(negedge clk);
    chk("mis_clear", {31'h0, ifc.misalign}, 32'h0);
    pop_chk("mis_tgt", 32'h100, s0);
`else
    chk("mis_pulse", {31'h0, ifc.misalign}, 32'h0);
    pop_chk("mis_tgt", 32'h200, s0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
